pipe_reg_ctl: RTL and testbench
===============================

// Module: pipe_reg_ctl
// PURPOSE
// - Parametrised inter-stage pipeline register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Carries a data payload and a control payload through STAGES back-to-back register slices.
// - Adds stall (hold), flush (bubble insert) and a per-slice valid bit, which the plain latch lacks.
// - The hazard unit drives en/flush; downstream stages consume valid_out/ctrl_out/data_out.
// PARAMETERS
// - DATA_W    32     width of data payload (pc+4, rdat1, rdat2, immext, ... concatenated)
// - CTRL_W    16     width of control payload (MemToReg, AluOp, regWEN, dMemWEN, Halt, ...)
// - STAGES    1      number of register slices in series; legal range 1..4
// - NOP_CTRL  '0     control value loaded on reset and on flush (bubble); must be write-free
// - CNT_W     16     width of statistics counters (PIPE_STATS_EN only)
// PORTS
// - CLK        in   1       clock, rising edge
// - nRST       in   1       asynchronous active-low reset
// - en         in   1       1 = advance; 0 = stall (all slices hold)
// - flush      in   1       1 = squash every slice at next edge
// - valid_in   in   1       payload at input is a real instruction
// - data_in    in   DATA_W  data payload in
// - ctrl_in    in   CTRL_W  control payload in
// - valid_out  out  1       valid bit of last slice
// - data_out   out  DATA_W  data payload of last slice
// - ctrl_out   out  CTRL_W  control payload of last slice
// - busy       out  1       OR of all slice valid bits
// - stats_clr  in   1       synchronous clear of counters (PIPE_STATS_EN only)
// - stall_cnt  out  CNT_W   cycles stalled holding a valid last slice (PIPE_STATS_EN only)
// - flush_cnt  out  CNT_W   valid slices squashed, summed over all flushes (PIPE_STATS_EN only)
// BEHAVIOUR
// - Reset (nRST=0, async, immediate):
//   - every slice: valid=0, ctrl=NOP_CTRL, data=0.
//   - outputs follow: valid_out=0, ctrl_out=NOP_CTRL, data_out=0, busy=0, counters=0.
// - Per rising edge, priority is flush > stall > advance:
//   - flush=1: every slice gets valid=0 and ctrl=NOP_CTRL; data is held. Applies regardless of en.
//   - flush=0, en=0: every slice holds valid, ctrl and data unchanged.
//   - flush=0, en=1: slice0 <= {valid_in, ctrl_in, data_in}; slice k <= slice k-1.
// - Latency: exactly STAGES edges with en=1 from input to outputs. No combinational path in->out.
// - Bubbles propagate as ordinary slices (valid=0), so downstream sees ctrl=NOP_CTRL.
// - valid_in=0 with en=1: ctrl_in/data_in are still captured; valid=0 marks the slice as a bubble.
// - Outputs are registered; busy is combinational OR of registered valid bits.
// - nRST asserted mid-stall or mid-flush: reset wins immediately. First edge after deassert obeys en/flush.
// - Outside 1..4, STAGES is a fatal elaboration error.
// CONFIGURATION
// - PIPE_STATS_EN defined: stats_clr, stall_cnt and flush_cnt exist.
//   - stall_cnt += 1 each edge with flush=0, en=0, valid_out=1.
//   - flush_cnt += (number of valid slices) each edge with flush=1.
//   - Both counters saturate at 2^CNT_W-1.
//   - stats_clr=1 zeroes both counters and takes priority over increment.
// - PIPE_STATS_EN undefined: those ports and counters are absent. Datapath behaviour is identical.
// TESTING
// - Reset: nRST=0 mid-run, STAGES=2 -> valid_out=0, ctrl_out=NOP_CTRL, data_out=0 with no clock edge.
// - Advance: STAGES=2, en=1, data_in=0xDEADBEEF, valid_in=1 at edge0 -> data_out=0xDEADBEEF, valid_out=1 after edge1.
// - Stall: hold en=0 for 3 edges with valid data_out=0x1234 -> outputs unchanged; stall_cnt=3.
// - Flush during stall: en=0, flush=1, 2 valid slices -> next edge valid_out=0, ctrl_out=NOP_CTRL,
//   data_out held, busy=0, flush_cnt=2.
// - Bubble propagation: valid_in=0, ctrl_in=0xFFFF, en=1, STAGES=1 -> valid_out=0, ctrl_out=0xFFFF
//   (capture occurs; downstream gates on valid).
// - Saturation: CNT_W=4, stall 20 cycles with valid -> stall_cnt=15; then stats_clr=1 for 1 edge -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_reg_ctl.sv
// Inter-stage pipeline register with stall, flush and per-slice valid bits, STAGES slices deep.
// Define PIPE_STATS_EN to add saturating stall/flush statistics counters.
module pipe_reg_ctl #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter int                STAGES   = 1,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              busy
`ifdef PIPE_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (STAGES < 1 || STAGES > 4 || CNT_W < 1 || DATA_W < 1 || CTRL_W < 1) begin : g_bad_param
    $fatal(1, "pipe_reg_ctl: STAGES must be 1..4 and all widths positive");
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];

  // Flush beats stall beats advance; a flush squashes valid/ctrl but leaves data untouched.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < STAGES; i++) ctrl_d[i] = NOP_CTRL;
    end else if (en) begin
      valid_d[0] = valid_in;
      ctrl_d[0]  = ctrl_in;
      data_d[0]  = data_in;
      for (int k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // NOTE: the slice array is a bank of flops, not a RAM, so every entry is reset to a known bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        ctrl_q[i] <= NOP_CTRL;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q[STAGES-1];
  assign ctrl_out  = ctrl_q[STAGES-1];
  assign data_out  = data_q[STAGES-1];
  assign busy      = |valid_q;

`ifdef PIPE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [2:0]       valid_count;
  logic [CNT_W+2:0] flush_sum;

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < STAGES; i++) valid_count = valid_count + 3'(valid_q[i]);
    // Extra headroom bits so a multi-slice squash near the ceiling still clamps correctly.
    flush_sum   = {3'b000, flush_cnt_q} + {{CNT_W{1'b0}}, valid_count};
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stats_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!flush && !en && valid_q[STAGES-1] && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush)
        flush_cnt_d = (flush_sum > {3'b000, CNT_MAX}) ? CNT_MAX : flush_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_ctl.sv
// Directed bench for pipe_reg_ctl: a 2-slice and a 1-slice instance share one stimulus stream.
// Counter checks are active when PIPE_STATS_EN is defined for the build.
module tb_pipe_reg_ctl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        valid_in;
  logic [31:0] data_in;
  logic [15:0] ctrl_in;
  logic        stats_clr;

  logic        v2, v1, busy2, busy1;
  logic [31:0] d2, d1;
  logic [15:0] c2, c1;
`ifdef PIPE_STATS_EN
  logic [3:0]  sc2, fc2;
  logic [15:0] sc1, fc1;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_reg_ctl #(.DATA_W(32), .CTRL_W(16), .STAGES(2), .CNT_W(4)) u_dut2 (
    .CLK(clk), .nRST(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v2), .data_out(d2),
    .ctrl_out(c2), .busy(busy2)
`ifdef PIPE_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(sc2), .flush_cnt(fc2)
`endif
  );

  pipe_reg_ctl #(.DATA_W(32), .CTRL_W(16), .STAGES(1)) u_dut1 (
    .CLK(clk), .nRST(rst_n), .en(en), .flush(flush), .valid_in(valid_in),
    .data_in(data_in), .ctrl_in(ctrl_in), .valid_out(v1), .data_out(d1),
    .ctrl_out(c1), .busy(busy1)
`ifdef PIPE_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic v,
                       input logic [31:0] d, input logic [15:0] c);
    en = e; flush = f; valid_in = v; data_in = d; ctrl_in = c;
  endtask

  initial begin
    rst_n = 1'b0;
    stats_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    #2;
    check("rst_valid", 64'(v2), 64'd0);
    check("rst_data", 64'(d2), 64'd0);
    check("rst_ctrl", 64'(c2), 64'd0);
    check("rst_busy", 64'(busy2), 64'd0);
`ifdef PIPE_STATS_EN
    check("rst_stall_cnt", 64'(sc2), 64'd0);
    check("rst_flush_cnt", 64'(fc2), 64'd0);
`endif
    #10 rst_n = 1'b1;

    // Advance: two-slice latency, one-slice latency.
    drive(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'h00A5);
    step();
    check("adv_e0_v2", 64'(v2), 64'd0);
    check("adv_e0_busy2", 64'(busy2), 64'd1);
    check("adv_e0_d1", 64'(d1), 64'hDEADBEEF);
    check("adv_e0_v1", 64'(v1), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h00001234, 16'h0011);
    step();
    check("adv_e1_d2", 64'(d2), 64'hDEADBEEF);
    check("adv_e1_v2", 64'(v2), 64'd1);
    check("adv_e1_c2", 64'(c2), 64'h00A5);
    drive(1'b1, 1'b0, 1'b1, 32'h00005555, 16'h0022);
    step();
    check("adv_e2_d2", 64'(d2), 64'h1234);
    check("adv_e2_c2", 64'(c2), 64'h0011);

    // Stall three edges with junk on the inputs.
    drive(1'b0, 1'b0, 1'b1, 32'h00000BAD, 16'h0BAD);
    step(3);
    check("stall_d2", 64'(d2), 64'h1234);
    check("stall_v2", 64'(v2), 64'd1);
    check("stall_c2", 64'(c2), 64'h0011);
    check("stall_d1", 64'(d1), 64'h5555);
`ifdef PIPE_STATS_EN
    check("stall_cnt3", 64'(sc2), 64'd3);
`endif

    // Flush while stalled: both slices of dut2 valid.
    drive(1'b0, 1'b1, 1'b1, 32'h00000BAD, 16'h0BAD);
    step();
    check("flush_v2", 64'(v2), 64'd0);
    check("flush_c2", 64'(c2), 64'h0);
    check("flush_d2_held", 64'(d2), 64'h1234);
    check("flush_busy2", 64'(busy2), 64'd0);
    check("flush_d1_held", 64'(d1), 64'h5555);
`ifdef PIPE_STATS_EN
    check("flush_cnt2", 64'(fc2), 64'd2);
    check("flush_stall_hold", 64'(sc2), 64'd3);
`endif

    // Bubble: captured ctrl/data travel with valid=0.
    drive(1'b1, 1'b0, 1'b0, 32'h0000CAFE, 16'hFFFF);
    step();
    check("bub_v1", 64'(v1), 64'd0);
    check("bub_c1", 64'(c1), 64'hFFFF);
    check("bub_d1", 64'(d1), 64'hCAFE);
    check("bub_busy2", 64'(busy2), 64'd0);
    step();
    check("bub_c2", 64'(c2), 64'hFFFF);
    check("bub_v2", 64'(v2), 64'd0);

    // Fill, stall, then async reset with no clock edge.
    drive(1'b1, 1'b0, 1'b1, 32'h00000077, 16'h0033);
    step(2);
    check("fill_d2", 64'(d2), 64'h77);
    drive(1'b0, 1'b0, 1'b1, 32'h00000077, 16'h0033);
    step();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_v2", 64'(v2), 64'd0);
    check("midrst_c2", 64'(c2), 64'h0);
    check("midrst_d2", 64'(d2), 64'h0);
    check("midrst_busy2", 64'(busy2), 64'd0);
`ifdef PIPE_STATS_EN
    check("midrst_stall_cnt", 64'(sc2), 64'd0);
`endif
    #1 rst_n = 1'b1;

    // First edge after deassert obeys en.
    drive(1'b1, 1'b0, 1'b1, 32'h00000099, 16'h0044);
    step();
    check("post_rst_d1", 64'(d1), 64'h99);
    check("post_rst_v2", 64'(v2), 64'd0);
    check("post_rst_busy2", 64'(busy2), 64'd1);

    // Flush with en=1 still squashes.
    drive(1'b1, 1'b1, 1'b1, 32'h000000AB, 16'h0055);
    step();
    check("flush_en_v1", 64'(v1), 64'd0);
    check("flush_en_c1", 64'(c1), 64'h0);
    check("flush_en_d1", 64'(d1), 64'h99);
`ifdef PIPE_STATS_EN
    check("flush_en_cnt", 64'(fc2), 64'd1);
`endif

    // Refill, then long stall for counter saturation.
    drive(1'b1, 1'b0, 1'b1, 32'h00000066, 16'h0066);
    step(2);
    check("refill_v2", 64'(v2), 64'd1);
    check("refill_d2", 64'(d2), 64'h66);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    step(20);
    check("sat_hold_d2", 64'(d2), 64'h66);
`ifdef PIPE_STATS_EN
    check("sat_stall_cnt", 64'(sc2), 64'd15);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("clr_stall_cnt", 64'(sc2), 64'd0);
    check("clr_flush_cnt", 64'(fc2), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
